// File: rtl/mux_frame_acc.sv
// Frame accumulator: sums FRAME_LEN accepted samples, queues each frame sum with a wrapping tag in a 2-entry show-ahead buffer.
// Optional build macro MUX_FRAME_ACC_SAT_EN clamps each pushed sum to the signed DATA_W range and flags it in overflow.
module mux_frame_acc #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 256,
   localparam int ACC_W    = DATA_W + $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic [ACC_W-1:0]  sum_data,
   output logic [7:0]        sum_tag,
   output logic              overflow
);
   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tag_q, tag_d;
   logic [1:0]       count_q, count_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [7:0]       head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;

   logic [ACC_W-1:0] din_ext;
   logic [ACC_W-1:0] sum_full;
   logic [ACC_W-1:0] push_val;
   logic             sat_hit;
   logic             push;
   logic             pop;

   assign din_ext  = {{(ACC_W-DATA_W){din[DATA_W-1]}}, din};
   assign sum_full = acc_q + din_ext;
   assign push     = din_valid && (cnt_q == LAST);
   assign pop      = valid_q && sum_ready;

`ifdef MUX_FRAME_ACC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   always_comb begin
      push_val = sum_full;
      sat_hit  = 1'b0;
      if ($signed(sum_full) > $signed(SAT_MAX)) begin
         push_val = SAT_MAX;
         sat_hit  = 1'b1;
      end else if ($signed(sum_full) < $signed(SAT_MIN)) begin
         push_val = SAT_MIN;
         sat_hit  = 1'b1;
      end
   end
`else
   assign push_val = sum_full;
   assign sat_hit  = 1'b0;
`endif

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tag_d       = tag_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      head_data_d = head_data_q;
      head_tag_d  = head_tag_q;
      tail_data_d = tail_data_q;
      tail_tag_d  = tail_tag_q;

      if (din_valid) begin
         if (push) begin
            acc_d = '0;
            cnt_d = '0;
            tag_d = tag_q + 8'd1;
         end else begin
            acc_d = sum_full;
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Pop first so a push sees the post-pop occupancy; a full buffer popping this cycle still accepts the new sum.
      if (pop) begin
         head_data_d = tail_data_q;
         head_tag_d  = tail_tag_q;
         count_d     = count_q - 2'd1;
      end

      if (push) begin
         if (count_d == 2'd0) begin
            head_data_d = push_val;
            head_tag_d  = tag_q;
            count_d     = 2'd1;
         end else if (count_d == 2'd1) begin
            tail_data_d = push_val;
            tail_tag_d  = tag_q;
            count_d     = 2'd2;
         end else begin
            ovf_d = 1'b1;
         end
         if (sat_hit) begin
            ovf_d = 1'b1;
         end
      end

      valid_d = (count_d != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         head_data_q <= '0;
         head_tag_q  <= '0;
         tail_data_q <= '0;
         tail_tag_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         head_data_q <= head_data_d;
         head_tag_q  <= head_tag_d;
         tail_data_q <= tail_data_d;
         tail_tag_q  <= tail_tag_d;
      end
   end

   assign sum_valid = valid_q;
   assign sum_data  = head_data_q;
   assign sum_tag   = head_tag_q;
   assign overflow  = ovf_q;
endmodule
